// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and a single-port word-addressed DMEM.
// Byte and halfword stores are done as read-modify-write of the containing word.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              dm_ena,
    output logic              dm_wena,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              req_bad;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // Request legality: illegal size, misalignment, or address beyond DMEM.
    always_comb begin
        req_bad = 1'b0;
        if (size == 2'b11)
            req_bad = 1'b1;
        if (size == 2'b01 && addr[0])
            req_bad = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00)
            req_bad = 1'b1;
        if (|addr[31:ADDR_W+2])
            req_bad = 1'b1;
    end

    // Next-state: loads and sub-word stores read first; word stores write directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (req_bad)
                        state_nxt = DONE;
                    else if (we && size == 2'b10)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = we_q ? WR : DONE;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction and extension of the word read from DMEM.
    always_comb begin
        byte_v   = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v   = dm_rdata[{addr_q[1], 4'b0000} +: 16];
        load_val = dm_rdata;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{sext_q & half_v[15]}}, half_v};
            default: load_val = dm_rdata;
        endcase
    end

    // Store data: old word with the addressed lane replaced, or the full word.
    always_comb begin
        merged = old_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // State register, request capture and load-result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sext;
                        addr_q  <= addr[ADDR_W+1:0];
                        wdata_q <= wdata;
                        err_q   <= req_bad;
                    end
                end
                RD: begin
                    old_q <= dm_rdata;
                    if (!we_q)
                        rdata_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    // DMEM strobes are gated by rst so an aborted write never reaches memory.
    always_comb begin
        ready    = (state == IDLE);
        done     = (state == DONE);
        err      = (state == DONE) && err_q;
        rdata    = rdata_q;
        dm_ena   = !rst && (state == RD || state == WR);
        dm_wena  = !rst && (state == WR);
        dm_addr  = '0;
        dm_wdata = '0;
        if (state == RD || state == WR)
            dm_addr = addr_q[ADDR_W+1:2];
        if (state == WR)
            dm_wdata = merged;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed test of mem_access_unit against a behavioural 32-word DMEM.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        dm_ena;
    logic        dm_wena;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_a;
    logic [31:0] pl_d;

    int n_checks;
    int n_fail;

    mem_access_unit #(.ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .dm_ena   (dm_ena),
        .dm_wena  (dm_wena),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DMEM model: combinational read, falling-edge write (or preload).
    assign dm_rdata = mem[dm_addr];
    always @(negedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (dm_ena && dm_wena)
            mem[dm_addr] <= dm_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // One request from IDLE to its done pulse, checking latency, DMEM traffic and result.
    task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                             input logic sx, input logic [31:0] a, input logic [31:0] wd,
                             input int exp_lat, input logic exp_err, input int exp_rd,
                             input int exp_wr, input logic [31:0] exp_rdata);
        int k;
        int rd_n;
        int wr_n;
        @(posedge clk);
        #1;
        k = 0;
        while (!ready && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        req   = 1'b1;
        we    = w;
        size  = sz;
        sext  = sx;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        #1;
        req  = 1'b0;
        k    = 1;
        rd_n = 0;
        wr_n = 0;
        while (!done && k < 8) begin
            if (dm_ena && !dm_wena)
                rd_n++;
            if (dm_ena && dm_wena)
                wr_n++;
            if (dm_ena)
                check({tag, "_dmaddr"}, 32'(dm_addr), 32'(a[6:2]));
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdcyc"}, 32'(rd_n), 32'(exp_rd));
        check({tag, "_wrcyc"}, 32'(wr_n), 32'(exp_wr));
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    logic [4:0] rbits;
    logic [4:0] dbits;
    logic [4:0] ebits;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        size  = 2'b00;
        sext  = 1'b0;
        addr  = '0;
        wdata = '0;
        pl_en = 1'b0;
        pl_a  = '0;
        pl_d  = '0;

        for (int i = 0; i < 32; i++)
            preload(5'(i), 32'h0);
        preload(5'd1, 32'h8899AABB);
        preload(5'd2, 32'h11223344);
        @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_dm_ena", 32'(dm_ena), 32'd0);
        check("rst_dm_wena", 32'(dm_wena), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        rst = 1'b0;

        // Loads from DMEM[1] = 0x8899AABB
        do_access("ldb_s6", 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 2, 1'b0, 1, 0, 32'hFFFFFF99);
        do_access("ldb_z6", 1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 2, 1'b0, 1, 0, 32'h00000099);
        do_access("ldb_s5", 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 2, 1'b0, 1, 0, 32'hFFFFFFAA);
        do_access("ldh_s4", 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 2, 1'b0, 1, 0, 32'hFFFFAABB);
        do_access("ldh_z6", 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 2, 1'b0, 1, 0, 32'h00008899);

        // Sub-word stores into DMEM[2] = 0x11223344
        do_access("sth_a", 1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF, 3, 1'b0, 1, 1, 32'h00008899);
        check("sth_mem2", mem[2], 32'hBEEF3344);
        do_access("stb_9", 1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFFFF5A, 3, 1'b0, 1, 1, 32'h00008899);
        check("stb_mem2", mem[2], 32'hBEEF5A44);
        do_access("ldw_8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2, 1'b0, 1, 0, 32'hBEEF5A44);

        // Word store / load at the top word
        do_access("stw_7c", 1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF, 2, 1'b0, 0, 1, 32'hBEEF5A44);
        check("stw_mem31", mem[31], 32'hDEADBEEF);
        do_access("ldw_7c", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 2, 1'b0, 1, 0, 32'hDEADBEEF);

        // Rejected requests: no DMEM access, rdata held
        do_access("err_ldw2", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1, 1'b1, 0, 0, 32'hDEADBEEF);
        do_access("err_ldb80", 1'b0, 2'b00, 1'b1, 32'h80, 32'h0, 1, 1'b1, 0, 0, 32'hDEADBEEF);
        do_access("err_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 1'b1, 0, 0, 32'hDEADBEEF);
        do_access("err_ldh5", 1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 1, 1'b1, 0, 0, 32'hDEADBEEF);
        do_access("err_stw80", 1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 1, 1'b1, 0, 0, 32'hDEADBEEF);
        check("err_mem0", mem[0], 32'h0);

        // Reset during the WR cycle of a byte store to DMEM[3]
        @(posedge clk);
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        req   = 1'b1;
        we    = 1'b1;
        size  = 2'b00;
        sext  = 1'b0;
        addr  = 32'hC;
        wdata = 32'h000000FF;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("abort_rd_ena", 32'(dm_ena), 32'd1);
        check("abort_rd_wena", 32'(dm_wena), 32'd0);
        @(posedge clk);
        #1;
        check("abort_wr_wena", 32'(dm_wena), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_gated_wena", 32'(dm_wena), 32'd0);
        check("abort_gated_ena", 32'(dm_ena), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_mem3", mem[3], 32'h0);
        check("abort_ready_after", 32'(ready), 32'd1);
        check("abort_done_after", 32'(done), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);

        // req held high across two word loads of DMEM[1]
        req   = 1'b1;
        we    = 1'b0;
        size  = 2'b10;
        sext  = 1'b0;
        addr  = 32'h4;
        wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rbits[i] = ready;
            dbits[i] = done;
            ebits[i] = dm_ena;
        end
        req = 1'b0;
        check("b2b_ready_seq", 32'(rbits), 32'h04);
        check("b2b_done_seq", 32'(dbits), 32'h12);
        check("b2b_ena_seq", 32'(ebits), 32'h09);
        check("b2b_err", 32'(err), 32'd0);
        check("b2b_rdata", rdata, 32'h8899AABB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, default 5, DMEM word-index width (2^ADDR_W words).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req  input  1  CPU access request, sampled only when ready=1.
REQ-005 SHALL have port: we  input  1  1=store, 0=load.
REQ-006 SHALL have port: size  input  2  00=byte, 01=halfword, 10=word; 11 is illegal.
REQ-007 SHALL have port: sext  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-008 SHALL have port: addr  input  32  byte address.
REQ-009 SHALL have port: wdata  input  32  store data, right-justified for byte/half.
REQ-010 SHALL have port: ready  output  1  idle, request accepted this cycle if req=1.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  output  1  valid with done: misaligned, out-of-range or illegal size.
REQ-013 SHALL have port: rdata  output  32  extended load result, held until next successful load.
REQ-014 SHALL have ports to DMEM: dm_ena out 1, dm_wena out 1, dm_addr out ADDR_W, dm_wdata out 32, dm_rdata in 32 (combinational read; DMEM writes on falling clk edge while dm_ena=dm_wena=1).

Function
REQ-015 SHALL implement states IDLE, RD, WR, DONE; ready=1 only in IDLE.
REQ-016 SHALL, in IDLE with req=1, register we, size, sext, addr, wdata and check: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:ADDR_W+2]!=0.
REQ-017 SHALL, on any check failure, go IDLE->DONE with err=1 and issue no DMEM access.
REQ-018 SHALL take paths: load IDLE->RD->DONE; word store IDLE->WR->DONE; byte/half store IDLE->RD->WR->DONE (read-modify-write).
REQ-019 SHALL, in DONE, assert done=1 for exactly one cycle and return to IDLE next cycle.
REQ-020 SHALL drive dm_addr = captured addr[ADDR_W+1:2] in RD and WR, 0 otherwise.
REQ-021 SHALL drive dm_ena=1 only in RD and WR, and dm_wena=1 only in WR; both are combinational from state and gated to 0 whenever rst=1.
REQ-022 SHALL, at the RD->next edge, capture dm_rdata; for loads, extract lane and extend into rdata, visible in the DONE cycle.
REQ-023 SHALL use little-endian lanes: byte offset k -> bits[8k+7:8k]; halfword offset 0 -> [15:0], offset 2 -> [31:16].
REQ-024 SHALL, in WR, drive dm_wdata = wdata for word stores, or the captured old word with only the addressed lane replaced by wdata[7:0]/[15:0].
REQ-025 SHALL drive dm_wdata=0 outside WR.
REQ-026 SHALL keep rdata unchanged on stores and on err completions.
REQ-027 SHALL ignore req while ready=0; no queuing.
REQ-028 SHALL give latencies (accept edge to done high): load 2 cycles, word store 2, sub-word store 3, error 1.

Reset
REQ-029 SHALL, with rst=1 at a rising edge, set state=IDLE, ready=1, done=0, err=0, rdata=0, and clear captured registers to 0.
REQ-030 SHALL abort any in-flight access on rst; a store in WR with rst=1 SHALL NOT write DMEM (REQ-021 gating); no done pulse results from the aborted access.

Verification
REQ-031 SHALL pass: DMEM[1]=0x8899AABB; load byte addr=0x6, sext=1 -> done after 2 cycles, rdata=0xFFFFFF99, err=0.
REQ-032 SHALL pass: DMEM[2]=0x11223344; store half addr=0xA, wdata=0x0000BEEF -> one RD then one WR cycle, DMEM[2]=0xBEEF3344, done after 3 cycles.
REQ-033 SHALL pass: store word addr=0x7C, wdata=0xDEADBEEF, then load word addr=0x7C -> DMEM[31]=0xDEADBEEF, rdata=0xDEADBEEF.
REQ-034 SHALL pass: load word addr=0x2, and separately load byte addr=0x80 -> each done after 1 cycle with err=1, dm_ena never asserted, rdata unchanged.
REQ-035 SHALL pass: rst=1 asserted during the WR cycle of a byte store to DMEM[3]=0x0 -> DMEM[3] stays 0x0, next cycle ready=1, done=0.
REQ-036 SHALL pass: req held high across back-to-back accepts -> second request is accepted only in the cycle after done, with one IDLE cycle between.
